sync_fifo_v2: RTL and testbench

- Second-generation synchronous FIFO: single clock, fully parametrised width, depth and almost-full/almost-empty thresholds.
- Full usable depth of 2**ADDR_WIDTH entries, with an (ADDR_WIDTH+1)-bit occupancy count.
- Registered status flags, a synchronous flush, and single-cycle overflow/underflow error pulses.
- Sits between producer and consumer datapaths in the same clock domain, replacing the first-generation FIFO in new designs.

---
 rtl/sync_fifo_v2_if.sv | 28 ++
 rtl/sync_fifo_v2.sv | 80 ++++++++
 tb/tb_sync_fifo_v2.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sync_fifo_v2_if.sv
// sync_fifo_v2_if: producer/consumer bundle for sync_fifo_v2 (enable, flush, write/read handshakes, status).
interface sync_fifo_v2_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  EN;
  logic                  clear;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   data_count;
  logic                  overflow;
  logic                  underflow;
  modport master (
    output EN, clear, wr_en, data_in, rd_en,
    input  data_out, rd_valid, empty, full, almost_empty, almost_full, data_count, overflow, underflow
  );
  modport slave (
    input  EN, clear, wr_en, data_in, rd_en,
    output data_out, rd_valid, empty, full, almost_empty, almost_full, data_count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2: single-clock FIFO with registered flags, flush and overflow/underflow pulses.
// Define SYNC_FIFO_V2_FWFT_EN for first-word-fall-through reads; default is 1-cycle registered reads.
module sync_fifo_v2 #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input logic           clk,
  input logic           reset,
  sync_fifo_v2_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_next;
  logic                  empty_q, full_q, aempty_q, afull_q, ovf_q, udf_q;
  logic                  rd_acc, wr_acc, go, wr_go, rd_go;
  // a full FIFO still takes a write when a read frees a slot in the same cycle
  always_comb begin
    rd_acc     = bus.rd_en & ~empty_q;
    wr_acc     = bus.wr_en & (~full_q | rd_acc);
    go         = bus.EN & ~bus.clear;
    wr_go      = go & wr_acc;
    rd_go      = go & rd_acc;
    count_next = bus.clear ? '0 : count + CW'(wr_acc) - CW'(rd_acc);
  end
  always_ff @(posedge clk)
    if (wr_go) mem[wr_ptr] <= bus.data_in;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else if (!bus.EN) begin
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr   <= bus.clear ? '0 : wr_ptr + ADDR_WIDTH'(wr_acc);
      rd_ptr   <= bus.clear ? '0 : rd_ptr + ADDR_WIDTH'(rd_acc);
      count    <= count_next;
      empty_q  <= count_next == '0;
      full_q   <= count_next == CW'(DEPTH);
      aempty_q <= count_next <= CW'(AEMPTY_THRESH);
      afull_q  <= count_next >= CW'(AFULL_THRESH);
      ovf_q    <= ~bus.clear & bus.wr_en & ~wr_acc;
      udf_q    <= ~bus.clear & bus.rd_en & ~rd_acc;
    end
  assign bus.data_count   = count;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = aempty_q;
  assign bus.almost_full  = afull_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
`ifdef SYNC_FIFO_V2_FWFT_EN
  assign bus.data_out = mem[rd_ptr];
  assign bus.rd_valid = ~empty_q;
`else
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  rv_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dout_q <= '0;
      rv_q   <= 1'b0;
    end else begin
      rv_q <= rd_go;
      if (rd_go) dout_q <= mem[rd_ptr];
    end
  assign bus.data_out = dout_q;
  assign bus.rd_valid = rv_q;
`endif
endmodule

// File: tb/tb_sync_fifo_v2.sv
// tb_sync_fifo_v2: randomized and directed checks of sync_fifo_v2 against a queue-based model.
module tb_sync_fifo_v2;
  localparam int DEPTH = 16;
  logic clk, reset;
  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  logic [31:0] m_dout;
  bit m_rv, m_ovf, m_udf;
  sync_fifo_v2_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) f();
  sync_fifo_v2 #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .AFULL_THRESH(12), .AEMPTY_THRESH(2))
    dut (.clk(clk), .reset(reset), .bus(f));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic cyc(bit we, bit re, logic [31:0] d, bit clr = 0, bit en = 1);
    f.wr_en = we; f.rd_en = re; f.data_in = d; f.clear = clr; f.EN = en;
    @(posedge clk); #1;
    if (!en) begin
      m_rv = 0; m_ovf = 0; m_udf = 0;
    end else if (clr) begin
      q.delete(); m_rv = 0; m_ovf = 0; m_udf = 0;
    end else begin
      bit can_rd = re && q.size() > 0;
      bit can_wr = we && (q.size() < DEPTH || can_rd);
      m_rv = can_rd; m_udf = re && !can_rd; m_ovf = we && !can_wr;
      if (can_rd) m_dout = q.pop_front();
      if (can_wr) q.push_back(d);
    end
    f.wr_en = 0; f.rd_en = 0; f.clear = 0; f.EN = 1;
  endtask
  task automatic test_reset;
    reset = 1; f.EN = 1; f.clear = 0; f.wr_en = 0; f.rd_en = 0; f.data_in = '0;
    q.delete(); m_dout = 0; m_rv = 0; m_ovf = 0; m_udf = 0;
    repeat (2) @(posedge clk);
    #3 reset = 0;
    @(negedge clk);
    checks++; if (f.data_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", f.data_count); end
    checks++; if ({f.empty, f.almost_empty, f.full, f.almost_full} !== 4'b1100) begin errors++; $display("FAIL reset_flags got %b want 1100", {f.empty, f.almost_empty, f.full, f.almost_full}); end
    checks++; if ({f.rd_valid, f.overflow, f.underflow} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {f.rd_valid, f.overflow, f.underflow}); end
    checks++; if (f.data_out !== 32'h0) begin errors++; $display("FAIL reset_dout got %h want 0", f.data_out); end
  endtask
  task automatic test_fill_overflow;
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, 32'(i));
      checks++; if (f.data_count !== 5'(i)) begin errors++; $display("FAIL fill_count got %0d want %0d", f.data_count, i); end
      checks++; if ({f.full, f.almost_full, f.almost_empty, f.empty} !== {i == 16, i >= 12, i <= 2, 1'b0}) begin errors++; $display("FAIL fill_flags at %0d got %b", i, {f.full, f.almost_full, f.almost_empty, f.empty}); end
    end
    cyc(1, 0, 32'h11);
    checks++; if (f.overflow !== 1'b1 || f.data_count !== 5'd16) begin errors++; $display("FAIL overflow got ovf=%b cnt=%0d want 1/16", f.overflow, f.data_count); end
    cyc(0, 0, 0);
    checks++; if (f.overflow !== 1'b0) begin errors++; $display("FAIL overflow_pulse got %b want 0", f.overflow); end
  endtask
  task automatic test_drain_underflow;
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 1, 0);
      checks++; if (f.rd_valid !== 1'b1 || f.data_out !== 32'(i)) begin errors++; $display("FAIL drain got rv=%b d=%h want 1/%h", f.rd_valid, f.data_out, i); end
      checks++; if (f.empty !== (i == 16)) begin errors++; $display("FAIL drain_empty at %0d got %b", i, f.empty); end
    end
    cyc(0, 1, 0);
    checks++; if ({f.underflow, f.rd_valid} !== 2'b10 || f.data_out !== 32'h10) begin errors++; $display("FAIL underflow got udf=%b rv=%b d=%h want 1/0/10", f.underflow, f.rd_valid, f.data_out); end
    cyc(0, 0, 0);
    checks++; if (f.underflow !== 1'b0) begin errors++; $display("FAIL underflow_pulse got %b want 0", f.underflow); end
  endtask
  task automatic test_back_to_back;
    for (int i = 1; i <= 16; i++) cyc(1, 0, 32'h100 + 32'(i));
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 32'h200 + 32'(i));
      checks++; if (f.data_count !== 5'd16 || f.overflow !== 1'b0 || f.rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_state got cnt=%0d ovf=%b rv=%b", f.data_count, f.overflow, f.rd_valid); end
      checks++; if (f.data_out !== (i < 16 ? 32'h101 + 32'(i) : 32'h200 + 32'(i - 16))) begin errors++; $display("FAIL b2b_data got %h at %0d", f.data_out, i); end
    end
    while (q.size() > 0) begin
      cyc(0, 1, 0);
      checks++; if (f.data_out !== m_dout) begin errors++; $display("FAIL b2b_drain got %h want %h", f.data_out, m_dout); end
    end
  endtask
  task automatic test_simul_empty;
    cyc(1, 1, 32'hA5A5A5A5);
    checks++; if ({f.underflow, f.rd_valid, f.empty} !== 3'b100 || f.data_count !== 5'd1) begin errors++; $display("FAIL simul_empty got udf=%b rv=%b e=%b cnt=%0d", f.underflow, f.rd_valid, f.empty, f.data_count); end
    cyc(0, 1, 0);
    checks++; if (f.data_out !== 32'hA5A5A5A5 || f.empty !== 1'b1) begin errors++; $display("FAIL simul_empty_read got %h e=%b", f.data_out, f.empty); end
  endtask
  task automatic test_clear;
    for (int i = 0; i < 5; i++) cyc(1, 0, 32'h300 + 32'(i));
    cyc(1, 0, 32'h3FF, 1);
    checks++; if (f.data_count !== 5'd0 || {f.empty, f.almost_empty, f.full, f.almost_full, f.overflow, f.rd_valid} !== 6'b110000) begin errors++; $display("FAIL clear got cnt=%0d flags=%b", f.data_count, {f.empty, f.almost_empty, f.full, f.almost_full, f.overflow, f.rd_valid}); end
    checks++; if (f.data_out !== 32'hA5A5A5A5) begin errors++; $display("FAIL clear_dout_hold got %h want a5a5a5a5", f.data_out); end
    cyc(1, 0, 32'hDEADBEEF);
    cyc(0, 1, 0);
    checks++; if (f.data_out !== 32'hDEADBEEF || f.rd_valid !== 1'b1) begin errors++; $display("FAIL clear_then_rw got %h rv=%b", f.data_out, f.rd_valid); end
  endtask
  task automatic test_async_reset_en;
    for (int i = 0; i < 3; i++) cyc(1, 0, 32'h400 + 32'(i));
    cyc(0, 1, 0);
    #3 reset = 1;
    #1;
    q.delete(); m_dout = 0;
    checks++; if (f.data_count !== 5'd0 || {f.empty, f.almost_empty, f.full, f.almost_full} !== 4'b1100) begin errors++; $display("FAIL async_reset got cnt=%0d flags=%b", f.data_count, {f.empty, f.almost_empty, f.full, f.almost_full}); end
    checks++; if (f.data_out !== 32'h0 || f.rd_valid !== 1'b0) begin errors++; $display("FAIL async_reset_dout got %h rv=%b", f.data_out, f.rd_valid); end
    #2 reset = 0;
    cyc(1, 0, 32'h55, 0, 0);
    cyc(0, 1, 0, 0, 0);
    checks++; if (f.data_count !== 5'd0 || {f.empty, f.overflow, f.underflow, f.rd_valid} !== 4'b1000) begin errors++; $display("FAIL en_low_empty got cnt=%0d %b", f.data_count, {f.empty, f.overflow, f.underflow, f.rd_valid}); end
    cyc(1, 0, 32'h600);
    cyc(1, 0, 32'h601);
    cyc(1, 1, 32'h602, 0, 0);
    checks++; if (f.data_count !== 5'd2 || f.rd_valid !== 1'b0 || f.data_out !== 32'h0) begin errors++; $display("FAIL en_low_hold got cnt=%0d rv=%b d=%h", f.data_count, f.rd_valid, f.data_out); end
    cyc(0, 1, 0);
    checks++; if (f.data_out !== 32'h600) begin errors++; $display("FAIL post_reset_first got %h want 600", f.data_out); end
    cyc(0, 1, 0);
  endtask
  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      int bias = (i / 100) % 2 == 0 ? 7 : 3;
      cyc($urandom_range(0, 9) < bias, $urandom_range(0, 9) >= bias, $urandom, $urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0);
      checks++; if (f.data_count !== 5'(q.size())) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, f.data_count, q.size()); end
      checks++; if ({f.empty, f.full, f.almost_empty, f.almost_full} !== {q.size() == 0, q.size() == DEPTH, q.size() <= 2, q.size() >= 12}) begin errors++; $display("FAIL rnd_flags cyc %0d got %b", i, {f.empty, f.full, f.almost_empty, f.almost_full}); end
      checks++; if ({f.rd_valid, f.overflow, f.underflow} !== {m_rv, m_ovf, m_udf}) begin errors++; $display("FAIL rnd_pulses cyc %0d got %b want %b", i, {f.rd_valid, f.overflow, f.underflow}, {m_rv, m_ovf, m_udf}); end
      checks++; if (f.data_out !== m_dout) begin errors++; $display("FAIL rnd_dout cyc %0d got %h want %h", i, f.data_out, m_dout); end
    end
  endtask
  initial begin
    test_reset;
    test_fill_overflow;
    test_drain_underflow;
    test_back_to_back;
    test_simul_empty;
    test_clear;
    test_async_reset_en;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
